// File: rtl/mig_cmd_arbiter_pkg.sv
// Shared definitions for the MIG command arbiter: command encodings and scheduler states.
package mig_pkg;
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } arb_state_e;
endpackage

// File: rtl/mig_cmd_arbiter_if.sv
// MIG user-interface command, write-data and read-return handshake bundle.
interface mig_cmd_arbiter_if;
    import mig_pkg::*;

    logic       app_rdy;
    logic       app_wdf_rdy;
    logic       app_rd_data_valid;
    logic       app_en;
    logic [2:0] app_cmd;
    logic       app_wdf_wren;
    logic       app_wdf_end;

    modport master (
        input  app_rdy, app_wdf_rdy, app_rd_data_valid,
        output app_en, app_cmd, app_wdf_wren, app_wdf_end
    );

    modport slave (
        output app_rdy, app_wdf_rdy, app_rd_data_valid,
        input  app_en, app_cmd, app_wdf_wren, app_wdf_end
    );
endinterface

// File: rtl/mig_cmd_arbiter_tag_fifo.sv
// Show-ahead tag FIFO recording which frame issued each in-flight read.
module tag_fifo
    import mig_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      count_q <= count_q + 1'b1;
            else if (pop_i && !push_i) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/mig_cmd_arbiter.sv
// Alternating write/read command scheduler for the MIG app_* interface with
// round-robin frame selection and tagged steering of returned read lines.
module mig_cmd_arbiter
    import mig_pkg::*;
#(
    parameter int NUM_FRAMES      = 7,
    parameter int MAX_OUTSTANDING = 8,
    parameter int RD_NUM_BITS     = $clog2(NUM_FRAMES)
) (
    input  logic                               clk,
    input  logic                               frame_rst,
    input  logic                               freeze,
    input  logic                               w_req,
    input  logic [NUM_FRAMES-1:0]              r_req,
    mig_cmd_arbiter_if.master                  app,
    output logic                               wr_cmd_sent,
    output logic                               rd_cmd_sent,
    output logic [RD_NUM_BITS-1:0]             rd_addr_num,
    output logic [RD_NUM_BITS-1:0]             rd_valid_num,
    output logic                               rd_data_we,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               tag_err
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0]       MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [RD_NUM_BITS-1:0] RR_INIT = RD_NUM_BITS'(NUM_FRAMES - 1);

    // First requesting frame after ptr, wrapping modulo NUM_FRAMES.
    function automatic logic [RD_NUM_BITS-1:0] rr_pick(input logic [NUM_FRAMES-1:0] req,
                                                       input logic [RD_NUM_BITS-1:0] ptr);
        logic [RD_NUM_BITS-1:0] pick;
        logic                   found;
        int                     idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= NUM_FRAMES; i++) begin
            idx = (int'(ptr) + i) % NUM_FRAMES;
            if (!found && req[idx]) begin
                pick  = idx[RD_NUM_BITS-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    arb_state_e             state_q, state_d;
    logic                   last_was_wr_q, last_was_wr_d;
    logic [RD_NUM_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [RD_NUM_BITS-1:0] rd_addr_num_q, rd_addr_num_d;
    logic                   cmd_done_q, cmd_done_d;
    logic                   dat_done_q, dat_done_d;
    logic                   tag_err_q, tag_err_d;
    logic                   w_elig, r_elig, cmd_fin, dat_fin;
    logic                   en, wren, push, pop, fifo_empty;
    logic [2:0]             cmd;
    logic [RD_NUM_BITS-1:0] rr_next, fifo_head;
    logic [CNT_W-1:0]       fifo_count;

    assign w_elig  = w_req & ~freeze;
    assign r_elig  = (|r_req) & (fifo_count < MAX_CNT);
    assign rr_next = rr_pick(r_req, rr_ptr_q);

    always_ff @(posedge clk) begin
        if (frame_rst) begin
            state_q       <= ST_IDLE;
            last_was_wr_q <= 1'b1;
            rr_ptr_q      <= RR_INIT;
            rd_addr_num_q <= '0;
            cmd_done_q    <= 1'b0;
            dat_done_q    <= 1'b0;
            tag_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_was_wr_q <= last_was_wr_d;
            rr_ptr_q      <= rr_ptr_d;
            rd_addr_num_q <= rd_addr_num_d;
            cmd_done_q    <= cmd_done_d;
            dat_done_q    <= dat_done_d;
            tag_err_q     <= tag_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_was_wr_d = last_was_wr_q;
        rr_ptr_d      = rr_ptr_q;
        rd_addr_num_d = rd_addr_num_q;
        cmd_done_d    = cmd_done_q;
        dat_done_d    = dat_done_q;
        cmd_fin       = 1'b0;
        dat_fin       = 1'b0;
        en            = 1'b0;
        wren          = 1'b0;
        cmd           = CMD_WRITE;
        wr_cmd_sent   = 1'b0;
        rd_cmd_sent   = 1'b0;
        push          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A write yields to an eligible read only when the last grant was a write.
                if (w_elig && (!r_elig || !last_was_wr_q)) begin
                    state_d       = ST_WR;
                    last_was_wr_d = 1'b1;
                    cmd_done_d    = 1'b0;
                    dat_done_d    = 1'b0;
                end else if (r_elig) begin
                    state_d       = ST_RD;
                    last_was_wr_d = 1'b0;
                    rr_ptr_d      = rr_next;
                    rd_addr_num_d = rr_next;
                end
            end
            ST_WR: begin
                en      = ~cmd_done_q;
                wren    = ~dat_done_q;
                cmd_fin = cmd_done_q | app.app_rdy;
                dat_fin = dat_done_q | app.app_wdf_rdy;
                if (cmd_fin && dat_fin) begin
                    wr_cmd_sent = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cmd_done_d = cmd_fin;
                    dat_done_d = dat_fin;
                end
            end
            ST_RD: begin
                en  = 1'b1;
                cmd = CMD_READ;
                if (app.app_rdy) begin
                    push        = 1'b1;
                    rd_cmd_sent = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop       = app.app_rd_data_valid & ~fifo_empty;
    assign tag_err_d = tag_err_q | (app.app_rd_data_valid & fifo_empty);

    tag_fifo #(
        .WIDTH (RD_NUM_BITS),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (frame_rst),
        .push_i  (push),
        .data_i  (rd_addr_num_q),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign app.app_en       = en;
    assign app.app_cmd      = cmd;
    assign app.app_wdf_wren = wren;
    assign app.app_wdf_end  = wren;
    assign rd_addr_num      = rd_addr_num_q;
    assign rd_valid_num     = fifo_head;
    assign rd_data_we       = pop;
    assign outstanding      = fifo_count;
    assign tag_err          = tag_err_q;
endmodule

// File: tb/tb_mig_cmd_arbiter.sv
// Directed bench for mig_cmd_arbiter: priority alternation, round-robin, flow limits,
// split write handshake, tag steering, freeze and tag error.
module tb_mig_cmd_arbiter;
    import mig_pkg::*;

    logic       clk;
    logic       frame_rst;
    logic       freeze;
    logic       w_req;
    logic [6:0] r_req;
    logic       wr_cmd_sent, rd_cmd_sent, rd_data_we, tag_err;
    logic [2:0] rd_addr_num, rd_valid_num;
    logic [3:0] outstanding;
    int         checks;
    int         failures;

    mig_cmd_arbiter_if app_if ();

    mig_cmd_arbiter #(
        .NUM_FRAMES      (7),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk          (clk),
        .frame_rst    (frame_rst),
        .freeze       (freeze),
        .w_req        (w_req),
        .r_req        (r_req),
        .app          (app_if),
        .wr_cmd_sent  (wr_cmd_sent),
        .rd_cmd_sent  (rd_cmd_sent),
        .rd_addr_num  (rd_addr_num),
        .rd_valid_num (rd_valid_num),
        .rd_data_we   (rd_data_we),
        .outstanding  (outstanding),
        .tag_err      (tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive point: just after the falling edge, well away from the active edge.
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_en(input string tag);
        int n;
        n = 0;
        nxt();
        while (app_if.app_en !== 1'b1 && n < 20) begin
            nxt();
            n++;
        end
        chk(tag, app_if.app_en, 1);
    endtask

    task automatic do_reset();
        frame_rst = 1'b1;
        nxt();
        nxt();
        frame_rst = 1'b0;
    endtask

    initial begin
        int n_en;
        int n;
        checks   = 0;
        failures = 0;
        freeze   = 1'b0;
        w_req    = 1'b0;
        r_req    = '0;
        app_if.app_rdy           = 1'b0;
        app_if.app_wdf_rdy       = 1'b0;
        app_if.app_rd_data_valid = 1'b0;
        nxt();
        do_reset();
        #1;
        chk("rst_en", app_if.app_en, 0);
        chk("rst_cmd", app_if.app_cmd, 0);
        chk("rst_wren", app_if.app_wdf_wren, 0);
        chk("rst_out", outstanding, 0);
        chk("rst_addr", rd_addr_num, 0);
        chk("rst_tagerr", tag_err, 0);

        // Round-robin between frames 0 and 2 until eight reads are in flight.
        r_req = 7'b0000101;
        app_if.app_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_en("rr_wait");
            chk("rr_cmd", app_if.app_cmd, 1);
            chk("rr_addr", rd_addr_num, (k % 2 == 0) ? 0 : 2);
            chk("rr_sent", rd_cmd_sent, 1);
            chk("rr_out", outstanding, k);
        end
        n_en = 0;
        for (int k = 0; k < 6; k++) begin
            nxt();
            if (app_if.app_en) n_en++;
        end
        chk("full_stall", n_en, 0);
        chk("full_out", outstanding, 8);
        r_req = '0;
        app_if.app_rd_data_valid = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_we", rd_data_we, 1);
            chk("drain_tag", rd_valid_num, (k % 2 == 0) ? 0 : 2);
            chk("drain_out", outstanding, 8 - k);
            nxt();
            if (k == 7) app_if.app_rd_data_valid = 1'b0;
            #1;
        end
        chk("drain_empty", outstanding, 0);
        chk("drain_noerr", tag_err, 0);

        // Strict alternation with a write and a read both pending, read first.
        do_reset();
        w_req = 1'b1;
        r_req = 7'b0001000;
        app_if.app_rdy     = 1'b1;
        app_if.app_wdf_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_en("alt_wait");
            #1;
            if (k % 2 == 0) begin
                chk("alt_rd_cmd", app_if.app_cmd, 1);
                chk("alt_rd_addr", rd_addr_num, 3);
                chk("alt_rd_sent", rd_cmd_sent, 1);
            end else begin
                chk("alt_wr_cmd", app_if.app_cmd, 0);
                chk("alt_wr_wren", app_if.app_wdf_wren, 1);
                chk("alt_wr_end", app_if.app_wdf_end, 1);
                chk("alt_wr_sent", wr_cmd_sent, 1);
            end
        end
        w_req = 1'b0;
        r_req = '0;

        // Write command accepted at +1, data at +4.
        do_reset();
        app_if.app_rdy     = 1'b0;
        app_if.app_wdf_rdy = 1'b0;
        w_req = 1'b1;
        wait_en("wr_wait");
        w_req = 1'b0;
        #1;
        chk("wr0_wren", app_if.app_wdf_wren, 1);
        chk("wr0_cmd", app_if.app_cmd, 0);
        chk("wr0_sent", wr_cmd_sent, 0);
        nxt();
        app_if.app_rdy = 1'b1;
        #1;
        chk("wr1_en", app_if.app_en, 1);
        chk("wr1_sent", wr_cmd_sent, 0);
        nxt();
        app_if.app_rdy = 1'b0;
        #1;
        chk("wr2_en", app_if.app_en, 0);
        chk("wr2_wren", app_if.app_wdf_wren, 1);
        nxt();
        #1;
        chk("wr3_wren", app_if.app_wdf_wren, 1);
        chk("wr3_sent", wr_cmd_sent, 0);
        nxt();
        app_if.app_wdf_rdy = 1'b1;
        #1;
        chk("wr4_sent", wr_cmd_sent, 1);
        chk("wr4_en", app_if.app_en, 0);
        nxt();
        app_if.app_wdf_rdy = 1'b0;
        #1;
        chk("wr5_wren", app_if.app_wdf_wren, 0);
        chk("wr5_sent", wr_cmd_sent, 0);
        chk("wr5_en", app_if.app_en, 0);

        // Reads to frames 1, 4, 6, then returns; the second return coincides with a push.
        do_reset();
        app_if.app_rdy = 1'b1;
        r_req = 7'b0000010;
        wait_en("tag_w1");
        chk("tag_a1", rd_addr_num, 1);
        r_req = 7'b0010000;
        wait_en("tag_w4");
        chk("tag_a4", rd_addr_num, 4);
        r_req = 7'b1000000;
        wait_en("tag_w6");
        chk("tag_a6", rd_addr_num, 6);
        chk("tag_out2", outstanding, 2);
        r_req = '0;
        nxt();
        app_if.app_rd_data_valid = 1'b1;
        #1;
        chk("tag_out3", outstanding, 3);
        chk("ret1_we", rd_data_we, 1);
        chk("ret1_tag", rd_valid_num, 1);
        nxt();
        app_if.app_rd_data_valid = 1'b0;
        r_req = 7'b0000100;
        #1;
        chk("ret1_out", outstanding, 2);
        wait_en("tag_w2");
        app_if.app_rd_data_valid = 1'b1;
        r_req = '0;
        #1;
        chk("ret2_sent", rd_cmd_sent, 1);
        chk("ret2_addr", rd_addr_num, 2);
        chk("ret2_we", rd_data_we, 1);
        chk("ret2_tag", rd_valid_num, 4);
        chk("ret2_out", outstanding, 2);
        nxt();
        #1;
        chk("ret3_out", outstanding, 2);
        chk("ret3_tag", rd_valid_num, 6);
        chk("ret3_we", rd_data_we, 1);
        nxt();
        app_if.app_rd_data_valid = 1'b0;
        #1;
        chk("ret4_out", outstanding, 1);
        chk("ret4_head", rd_valid_num, 2);
        chk("ret4_we", rd_data_we, 0);

        // Freeze blocks writes but not reads.
        do_reset();
        freeze = 1'b1;
        w_req  = 1'b1;
        app_if.app_rdy     = 1'b1;
        app_if.app_wdf_rdy = 1'b1;
        n_en = 0;
        for (int k = 0; k < 5; k++) begin
            nxt();
            if (app_if.app_en) n_en++;
        end
        chk("frz_noen", n_en, 0);
        r_req = 7'b0100000;
        wait_en("frz_rd_wait");
        r_req = '0;
        #1;
        chk("frz_rd_cmd", app_if.app_cmd, 1);
        chk("frz_rd_addr", rd_addr_num, 5);
        n_en = 0;
        for (int k = 0; k < 4; k++) begin
            nxt();
            if (app_if.app_en) n_en++;
        end
        chk("frz_noen2", n_en, 0);
        freeze = 1'b0;
        n = 0;
        do begin
            nxt();
            n++;
        end while (app_if.app_en !== 1'b1 && n < 10);
        w_req = 1'b0;
        chk("frz_lat", (n <= 2) ? 1 : 0, 1);
        chk("frz_wr_cmd", app_if.app_cmd, 0);
        chk("frz_wr_wren", app_if.app_wdf_wren, 1);

        // Data return with nothing outstanding.
        do_reset();
        app_if.app_rd_data_valid = 1'b1;
        #1;
        chk("err_we", rd_data_we, 0);
        chk("err_pre", tag_err, 0);
        nxt();
        app_if.app_rd_data_valid = 1'b0;
        #1;
        chk("err_set", tag_err, 1);
        nxt();
        nxt();
        chk("err_sticky", tag_err, 1);
        chk("err_out", outstanding, 0);
        do_reset();
        #1;
        chk("err_clr", tag_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
